// File: rtl/moxie_pkg.sv
// rtl/moxie_pkg.sv - shared Moxie constants, fetch FSM encoding and instruction-length decode
package moxie_pkg;

  localparam logic [31:0] BOOT_ADDRESS = 32'h0000_1000;

  // Bit n set => opcode n (0x00..0x3F) is a 48-bit instruction:
  // 0x01 0x03 0x08 0x09 0x0C 0x0D 0x0F-0x18 0x1A 0x1B 0x1D 0x20 0x24 0x36-0x39
  localparam logic [63:0] LONG_OPCODE_MASK = 64'h03C0_0011_2DFF_B30A;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_WAIT         = 2'd1,
    ST_WAIT_DISCARD = 2'd2
  } fetch_state_t;

  function automatic logic insn_is_long(input logic [7:0] opcode);
    return (opcode[7:6] == 2'b00) && LONG_OPCODE_MASK[opcode[5:0]];
  endfunction

endpackage

// File: rtl/moxie_fetch_queue_if.sv
// rtl/moxie_fetch_queue_if.sv - instruction-memory, redirect and decode handshake bundle
interface moxie_fetch_queue_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        flush;
  logic [31:0] flush_pc;
  logic        insn_valid;
  logic        insn_ready;
  logic [47:0] insn;
  logic        insn_long;
  logic [31:0] insn_pc;

  modport master (
    output imem_req, imem_addr, insn_valid, insn, insn_long, insn_pc,
    input  imem_ack, imem_data, flush, flush_pc, insn_ready
  );

  modport slave (
    input  imem_req, imem_addr, insn_valid, insn, insn_long, insn_pc,
    output imem_ack, imem_data, flush, flush_pc, insn_ready
  );

endinterface

// File: rtl/moxie_insn_length.sv
// rtl/moxie_insn_length.sv - combinational 16/48-bit instruction length decode
module moxie_insn_length
  import moxie_pkg::*;
(
  input  logic [7:0] opcode,
  output logic       is_long
);

  assign is_long = insn_is_long(opcode);

endmodule

// File: rtl/moxie_fetch_queue.sv
// rtl/moxie_fetch_queue.sv - 4-halfword instruction fetch queue; MOXIE_FETCH_BYPASS_EN enables ack-cycle bypass
module moxie_fetch_queue
  import moxie_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  moxie_fetch_queue_if.master bus
);

  fetch_state_t state;
  logic [15:0]  hw [4];
  logic [1:0]   head;
  logic [1:0]   tail;
  logic [2:0]   count;
  logic [31:0]  fetch_addr;
  logic [31:0]  pc;
  logic         skip_first;

  logic [15:0]  h0, h1, h2;
  logic         buf_long;
  logic         buf_valid;
  logic         ack_write;
  logic [1:0]   fill;
  logic         out_valid;
  logic         out_long;
  logic [47:0]  out_insn;
  logic         take;
  logic [1:0]   take_len;

  assign h0 = hw[head];
  assign h1 = hw[head + 2'd1];
  assign h2 = hw[head + 2'd2];

  moxie_insn_length u_len_buf (
    .opcode  (h0[15:8]),
    .is_long (buf_long)
  );

  assign buf_valid = buf_long ? (count >= 3'd3) : (count != 3'd0);

  // Data acked into a flushed queue is stale and never written.
  assign ack_write = (state == ST_WAIT) && bus.imem_ack && !bus.flush;
  assign fill      = !ack_write ? 2'd0 : (skip_first ? 2'd1 : 2'd2);

`ifdef MOXIE_FETCH_BYPASS_EN
  logic bypass;
  logic bypass_long;

  moxie_insn_length u_len_byp (
    .opcode  (bus.imem_data[31:24]),
    .is_long (bypass_long)
  );

  assign bypass = ack_write && (count == 3'd0) && !skip_first;
`endif

  always_comb begin
    out_valid = buf_valid;
    out_long  = buf_long;
    out_insn  = buf_long ? {h0, h1, h2} : {h0, 32'h0};
`ifdef MOXIE_FETCH_BYPASS_EN
    // A bypassed halfword is still written below; consuming it just advances head.
    if (bypass) begin
      out_valid = !bypass_long;
      out_long  = bypass_long;
      out_insn  = {bus.imem_data[31:16], 32'h0};
    end
`endif
  end

  assign bus.insn_valid = out_valid;
  assign bus.insn_long  = out_long;
  assign bus.insn       = out_insn;
  assign bus.insn_pc    = pc;

  assign take     = out_valid && bus.insn_ready && !bus.flush;
  assign take_len = !take ? 2'd0 : (out_long ? 2'd3 : 2'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      bus.imem_req  <= 1'b0;
      bus.imem_addr <= BOOT_ADDRESS;
      fetch_addr    <= BOOT_ADDRESS;
      pc            <= BOOT_ADDRESS;
      head          <= 2'd0;
      tail          <= 2'd0;
      count         <= 3'd0;
      skip_first    <= 1'b0;
      for (int i = 0; i < 4; i++) hw[i] <= 16'h0;
    end else begin
      if (bus.flush) begin
        head       <= 2'd0;
        tail       <= 2'd0;
        count      <= 3'd0;
        fetch_addr <= bus.flush_pc & ~32'h3;
        pc         <= bus.flush_pc & ~32'h1;
        skip_first <= bus.flush_pc[1];
      end else begin
        if (ack_write) begin
          if (skip_first) begin
            hw[tail] <= bus.imem_data[15:0];
          end else begin
            hw[tail]         <= bus.imem_data[31:16];
            hw[tail + 2'd1]  <= bus.imem_data[15:0];
          end
          skip_first <= 1'b0;
          fetch_addr <= fetch_addr + 32'd4;
        end
        tail  <= tail + fill;
        head  <= head + take_len;
        count <= count + {1'b0, fill} - {1'b0, take_len};
        pc    <= pc + {29'd0, take_len, 1'b0};
      end

      case (state)
        ST_IDLE: begin
          if (count <= 3'd2 && !bus.flush) begin
            bus.imem_req  <= 1'b1;
            bus.imem_addr <= fetch_addr;
            state         <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.imem_ack) bus.imem_req <= 1'b0;
          if (bus.flush) state <= ST_WAIT_DISCARD;
          else if (bus.imem_ack) state <= ST_IDLE;
        end
        ST_WAIT_DISCARD: begin
          // Entered with no request pending when the flush coincided with the ack.
          if (bus.imem_ack || !bus.imem_req) begin
            bus.imem_req <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_moxie_fetch_queue.sv
// tb/tb_moxie_fetch_queue.sv - directed self-checking bench for moxie_fetch_queue
module tb_moxie_fetch_queue;

  logic clk = 1'b0;
  logic reset;

  moxie_fetch_queue_if bus ();

  moxie_fetch_queue dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] mem [logic [31:0]];
  bit ack_hold = 1'b0;
  int pulse_req = 0;
  int pulse_done = 0;
  int ack_cnt = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  // Memory responder: acks in the request cycle unless held; pulse_req forces a stray ack.
  initial begin
    bus.imem_ack  = 1'b0;
    bus.imem_data = 32'h0;
    forever begin
      @(negedge clk);
      if (pulse_req != pulse_done) begin
        pulse_done++;
        bus.imem_ack  = 1'b1;
        bus.imem_data = mem_rd(bus.imem_addr);
        ack_cnt++;
      end else if (bus.imem_req && !bus.imem_ack && !ack_hold) begin
        bus.imem_ack  = 1'b1;
        bus.imem_data = mem_rd(bus.imem_addr);
        ack_cnt++;
      end else begin
        bus.imem_ack  = 1'b0;
        bus.imem_data = 32'h0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    bus.flush      = 1'b0;
    bus.flush_pc   = 32'h0;
    bus.insn_ready = 1'b0;
    ack_hold       = 1'b0;
    repeat (2) step();
    mem.delete();
  endtask

  task automatic next_insn(output bit ok, output logic [47:0] i, output logic [31:0] p, output logic l);
    ok = 1'b0; i = '0; p = '0; l = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      if (bus.insn_valid && bus.insn_ready) begin
        ok = 1'b1; i = bus.insn; p = bus.insn_pc; l = bus.insn_long;
      end
      step();
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", bus.imem_req); end
    n_cmp++; if (bus.imem_addr !== 32'h1000) begin n_fail++; $display("FAIL reset_addr got %h exp 00001000", bus.imem_addr); end
    n_cmp++; if (bus.insn_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", bus.insn_valid); end
    n_cmp++; if (bus.insn !== 48'h0) begin n_fail++; $display("FAIL reset_insn got %h exp 0", bus.insn); end
    n_cmp++; if (bus.insn_long !== 1'b0) begin n_fail++; $display("FAIL reset_long got %b exp 0", bus.insn_long); end
    n_cmp++; if (bus.insn_pc !== 32'h1000) begin n_fail++; $display("FAIL reset_pc got %h exp 00001000", bus.insn_pc); end
  endtask

  task automatic test_short();
    do_reset();
    mem[32'h1000] = 32'h2600_2700;
    reset = 1'b1;
    step();
    n_cmp++; if ({bus.imem_req, bus.imem_addr, bus.insn_valid} !== {1'b1, 32'h1000, 1'b0})
      begin n_fail++; $display("FAIL short_req got req=%b addr=%h valid=%b exp 1 00001000 0", bus.imem_req, bus.imem_addr, bus.insn_valid); end
    step();
    n_cmp++; if (bus.insn_valid !== 1'b1) begin n_fail++; $display("FAIL short_latency got valid=%b exp 1", bus.insn_valid); end
    n_cmp++; if ({bus.insn, bus.insn_pc, bus.insn_long} !== {48'h2600_0000_0000, 32'h1000, 1'b0})
      begin n_fail++; $display("FAIL short_first got %h %h %b exp 260000000000 00001000 0", bus.insn, bus.insn_pc, bus.insn_long); end
    bus.insn_ready = 1'b1;
    step();
    n_cmp++; if ({bus.insn_valid, bus.insn, bus.insn_pc, bus.insn_long} !== {1'b1, 48'h2700_0000_0000, 32'h1002, 1'b0})
      begin n_fail++; $display("FAIL short_second got %b %h %h %b exp 1 270000000000 00001002 0", bus.insn_valid, bus.insn, bus.insn_pc, bus.insn_long); end
  endtask

  task automatic test_long();
    bit ok; logic [47:0] i; logic [31:0] p; logic l;
    do_reset();
    mem[32'h1000] = 32'h0100_1234;
    mem[32'h1004] = 32'h5678_2600;
    bus.insn_ready = 1'b1;
    reset = 1'b1;
    repeat (2) step();
    n_cmp++; if (bus.insn_valid !== 1'b0) begin n_fail++; $display("FAIL long_partial got valid=%b exp 0", bus.insn_valid); end
    next_insn(ok, i, p, l);
    n_cmp++; if ({ok, i, p, l} !== {1'b1, 48'h0100_1234_5678, 32'h1000, 1'b1})
      begin n_fail++; $display("FAIL long_insn got %b %h %h %b exp 1 010012345678 00001000 1", ok, i, p, l); end
    next_insn(ok, i, p, l);
    n_cmp++; if ({ok, i, p, l} !== {1'b1, 48'h2600_0000_0000, 32'h1006, 1'b0})
      begin n_fail++; $display("FAIL long_next got %b %h %h %b exp 1 260000000000 00001006 0", ok, i, p, l); end
  endtask

  task automatic test_lengths();
    bit ok; logic [47:0] i; logic [31:0] p; logic l;
    logic [80:0] exp [4];
    exp = '{{48'h1900_0000_0000, 32'h1000, 1'b0}, {48'h3900_AAAA_BBBB, 32'h1002, 1'b1},
            {48'h0F00_1111_2222, 32'h1008, 1'b1}, {48'h3A00_0000_0000, 32'h100E, 1'b0}};
    do_reset();
    mem[32'h1000] = 32'h1900_3900;
    mem[32'h1004] = 32'hAAAA_BBBB;
    mem[32'h1008] = 32'h0F00_1111;
    mem[32'h100C] = 32'h2222_3A00;
    bus.insn_ready = 1'b1;
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      next_insn(ok, i, p, l);
      n_cmp++; if ({ok, i, p, l} !== {1'b1, exp[k]})
        begin n_fail++; $display("FAIL lengths[%0d] got %b %h %h %b exp %h", k, ok, i, p, l, exp[k]); end
    end
  endtask

  task automatic test_backpressure();
    bit ok; logic [47:0] i; logic [31:0] p; logic l;
    int base;
    logic [80:0] exp [6];
    exp = '{{48'h2600_0000_0000, 32'h1000, 1'b0}, {48'h2700_0000_0000, 32'h1002, 1'b0},
            {48'h2601_0000_0000, 32'h1004, 1'b0}, {48'h2701_0000_0000, 32'h1006, 1'b0},
            {48'h2602_0000_0000, 32'h1008, 1'b0}, {48'h2702_0000_0000, 32'h100A, 1'b0}};
    do_reset();
    mem[32'h1000] = 32'h2600_2700;
    mem[32'h1004] = 32'h2601_2701;
    mem[32'h1008] = 32'h2602_2702;
    base = ack_cnt;
    reset = 1'b1;
    repeat (8) step();
    n_cmp++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_req_stop got %b exp 0", bus.imem_req); end
    n_cmp++; if (ack_cnt - base !== 2) begin n_fail++; $display("FAIL bp_acks got %0d exp 2", ack_cnt - base); end
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if ({bus.insn_valid, bus.insn, bus.insn_pc, bus.insn_long} !== {1'b1, 48'h2600_0000_0000, 32'h1000, 1'b0})
        begin n_fail++; $display("FAIL bp_stable[%0d] got %b %h %h %b exp 1 260000000000 00001000 0", c, bus.insn_valid, bus.insn, bus.insn_pc, bus.insn_long); end
      step();
    end
    bus.insn_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      next_insn(ok, i, p, l);
      n_cmp++; if ({ok, i, p, l} !== {1'b1, exp[k]})
        begin n_fail++; $display("FAIL bp_resume[%0d] got %b %h %h %b exp %h", k, ok, i, p, l, exp[k]); end
    end
  endtask

  task automatic test_flush_wait();
    bit ok; logic [47:0] i; logic [31:0] p; logic l;
    logic [80:0] exp [3];
    exp = '{{48'h2712_0000_0000, 32'h2002, 1'b0}, {48'h2713_0000_0000, 32'h2004, 1'b0},
            {48'h2714_0000_0000, 32'h2006, 1'b0}};
    do_reset();
    mem[32'h1000] = 32'h2600_2700;
    mem[32'h2000] = 32'h0000_2712;
    mem[32'h2004] = 32'h2713_2714;
    ack_hold = 1'b1;
    bus.insn_ready = 1'b1;
    reset = 1'b1;
    step();
    bus.flush = 1'b1;
    bus.flush_pc = 32'h2002;
    step();
    bus.flush = 1'b0;
    n_cmp++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h1000})
      begin n_fail++; $display("FAIL fw_outstanding got req=%b addr=%h exp 1 00001000", bus.imem_req, bus.imem_addr); end
    ack_hold = 1'b0;
    step();
    n_cmp++; if ({bus.insn_valid, bus.imem_req} !== 2'b00)
      begin n_fail++; $display("FAIL fw_discard got valid=%b req=%b exp 0 0", bus.insn_valid, bus.imem_req); end
    step();
    n_cmp++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h2000})
      begin n_fail++; $display("FAIL fw_redirect got req=%b addr=%h exp 1 00002000", bus.imem_req, bus.imem_addr); end
    for (int k = 0; k < 3; k++) begin
      next_insn(ok, i, p, l);
      n_cmp++; if ({ok, i, p, l} !== {1'b1, exp[k]})
        begin n_fail++; $display("FAIL fw_stream[%0d] got %b %h %h %b exp %h", k, ok, i, p, l, exp[k]); end
    end
  endtask

  task automatic test_flush_ack_consume();
    bit ok; bit hit; logic [47:0] i; logic [31:0] p; logic l;
    int base;
    do_reset();
    mem[32'h1000] = 32'h2600_2700;
    mem[32'h1004] = 32'h2601_2701;
    mem[32'h3000] = 32'h2730_2731;
    bus.insn_ready = 1'b1;
    reset = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      step();
      hit = bus.imem_req && (bus.imem_addr == 32'h1004);
    end
    n_cmp++; if ({hit, bus.insn_valid, bus.insn, bus.insn_pc} !== {1'b1, 1'b1, 48'h2700_0000_0000, 32'h1002})
      begin n_fail++; $display("FAIL fac_setup got %b %b %h %h exp 1 1 270000000000 00001002", hit, bus.insn_valid, bus.insn, bus.insn_pc); end
    base = ack_cnt;
    bus.flush = 1'b1;
    bus.flush_pc = 32'h3000;
    step();
    bus.flush = 1'b0;
    n_cmp++; if ({bus.insn_valid, bus.imem_req, ack_cnt - base} !== {1'b0, 1'b0, 32'd1})
      begin n_fail++; $display("FAIL fac_empty got valid=%b req=%b acks=%0d exp 0 0 1", bus.insn_valid, bus.imem_req, ack_cnt - base); end
    next_insn(ok, i, p, l);
    n_cmp++; if ({ok, i, p, l} !== {1'b1, 48'h2730_0000_0000, 32'h3000, 1'b0})
      begin n_fail++; $display("FAIL fac_first got %b %h %h %b exp 1 273000000000 00003000 0", ok, i, p, l); end
    next_insn(ok, i, p, l);
    n_cmp++; if ({ok, i, p, l} !== {1'b1, 48'h2731_0000_0000, 32'h3002, 1'b0})
      begin n_fail++; $display("FAIL fac_second got %b %h %h %b exp 1 273100000000 00003002 0", ok, i, p, l); end
  endtask

  task automatic test_reset_mid_request();
    bit ok; logic [47:0] i; logic [31:0] p; logic l;
    do_reset();
    mem[32'h1000] = 32'h2600_2700;
    ack_hold = 1'b1;
    bus.insn_ready = 1'b1;
    reset = 1'b1;
    step();
    n_cmp++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL rm_pending got %b exp 1", bus.imem_req); end
    reset = 1'b0;
    #1;
    n_cmp++; if ({bus.imem_req, bus.imem_addr, bus.insn_valid, bus.insn, bus.insn_pc} !== {1'b0, 32'h1000, 1'b0, 48'h0, 32'h1000})
      begin n_fail++; $display("FAIL rm_async got %b %h %b %h %h exp 0 00001000 0 0 00001000", bus.imem_req, bus.imem_addr, bus.insn_valid, bus.insn, bus.insn_pc); end
    step();
    reset = 1'b1;
    pulse_req++;
    step();
    n_cmp++; if ({bus.imem_req, bus.imem_addr, bus.insn_valid} !== {1'b1, 32'h1000, 1'b0})
      begin n_fail++; $display("FAIL rm_rerequest got req=%b addr=%h valid=%b exp 1 00001000 0", bus.imem_req, bus.imem_addr, bus.insn_valid); end
    step();
    n_cmp++; if (bus.insn_valid !== 1'b0) begin n_fail++; $display("FAIL rm_late_ack got valid=%b exp 0", bus.insn_valid); end
    ack_hold = 1'b0;
    next_insn(ok, i, p, l);
    n_cmp++; if ({ok, i, p, l} !== {1'b1, 48'h2600_0000_0000, 32'h1000, 1'b0})
      begin n_fail++; $display("FAIL rm_first got %b %h %h %b exp 1 260000000000 00001000 0", ok, i, p, l); end
    next_insn(ok, i, p, l);
    n_cmp++; if ({ok, i, p, l} !== {1'b1, 48'h2700_0000_0000, 32'h1002, 1'b0})
      begin n_fail++; $display("FAIL rm_second got %b %h %h %b exp 1 270000000000 00001002 0", ok, i, p, l); end
  endtask

  initial begin
    reset          = 1'b0;
    bus.flush      = 1'b0;
    bus.flush_pc   = 32'h0;
    bus.insn_ready = 1'b0;
    test_reset();
    test_short();
    test_long();
    test_lengths();
    test_backpressure();
    test_flush_wait();
    test_flush_ack_consume();
    test_reset_mid_request();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

endmodule

// File: doc/moxie_fetch_queue.md
# moxie_fetch_queue

Instruction fetch queue for the Moxie core: issues 32-bit word reads to instruction memory, packs the returned words into a 64-bit circular buffer of four 16-bit halfwords, and presents whole 16-bit or 48-bit instructions, together with their PC, to the decode stage through a valid/ready handshake. It sits between the instruction-memory port and decode. It absorbs the mismatch between the 32-bit memory path and variable-length instructions, and handles redirects (branches/jumps) via a flush input.

## Interface
- BOOT_ADDRESS, 32'h00001000, fetch PC after reset.
- clk  in  1  core clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  read request; held high until imem_ack.
- imem_addr  out  32  word-aligned read address; bits [1:0] always 0.
- imem_ack  in  1  read data valid this cycle; completes the request.
- imem_data  in  32  read data, big-endian: [31:16] is the lower-addressed halfword.
- flush  in  1  redirect fetch to flush_pc this cycle.
- flush_pc  in  32  redirect target; bit 0 ignored (treated as 0).
- insn_valid  out  1  insn/insn_pc/insn_long are valid.
- insn_ready  in  1  decode accepts the instruction this cycle.
- insn  out  48  instruction; opcode halfword in [47:32]; [31:0] zero for 16-bit instructions.
- insn_long  out  1  1 = 48-bit instruction, 0 = 16-bit.
- insn_pc  out  32  address of the first halfword of insn.

## Operation
- Buffer: 4 halfword slots, 2-bit head pointer, 2-bit tail pointer, 3-bit count (0..4). Each accepted imem_ack writes 2 halfwords at the tail (tail += 2, count += 2).
- Length: insn_long = insn_is_long(head halfword [15:8]). The 48-bit opcodes are: 0x01, 0x03, 0x08, 0x09, 0x0C, 0x0D, 0x0F–0x18, 0x1A, 0x1B, 0x1D, 0x20, 0x24, 0x36–0x39.
- insn_valid = count>=1 for a short instruction, or count>=3 for a long instruction. Outputs are driven from the head; pointer arithmetic wraps mod 4.
- Consume on insn_valid && insn_ready: head += 1 or 3, count -= 1 or 3, insn_pc += 2 or 6.
- Fetch FSM:
  - IDLE: if count<=2 and no flush, assert imem_req, go to WAIT.
  - WAIT: on imem_ack, write the data, fetch_addr += 4, go to IDLE.
  - WAIT_DISCARD: on imem_ack, drop the data, go to IDLE.
- Flush has priority over consume and ack in the same cycle:
  - count, head and tail reset to 0; insn_valid drops the next cycle.
  - fetch_addr = {flush_pc[31:2],2'b00}; insn_pc = {flush_pc[31:1],1'b0}; skip_first = flush_pc[1].
  - A flush while in WAIT, or in the cycle an ack arrives, goes to WAIT_DISCARD; the outstanding request is never aborted.
- skip_first: the first word written after a flush stores only [15:0] (count += 1, tail += 1), then the flag clears.
- Count arithmetic: next_count = count + fill(0/1/2) - consume(0/1/3). Never exceeds 4, because a request issues only at count<=2 and only one request is outstanding.
- Reset values:
  - imem_req=0, imem_addr=BOOT_ADDRESS, insn_valid=0, insn=0, insn_long=0, insn_pc=BOOT_ADDRESS.
  - FSM=IDLE, count=0, skip_first=0.
- Reset asserted mid-request: the request is dropped. Any late ack while in IDLE is ignored.

## Timing
- imem_req and imem_addr are registered. The first request is asserted the first cycle after reset deasserts.
- Data acked in cycle N is visible on insn_valid in cycle N+1.
- Minimum fetch-to-decode latency from IDLE with an empty buffer: request cycle + ack cycle + 1.
- insn, insn_long and insn_pc are stable while insn_valid=1 and insn_ready=0.
- Peak throughput is one 16-bit instruction per cycle with single-cycle acks.

## Configuration
- MOXIE_FETCH_BYPASS_EN defined: when count==0, not skip_first and no flush, acked data drives insn/insn_valid combinationally in the ack cycle. The data is still written to the buffer only if it is not consumed in full. This saves 1 cycle of latency.
- Not defined: all outputs come from the buffer; latency is as given in Timing.

## Structure
- moxie_pkg holds BOOT_ADDRESS, the opcode constants, the fetch FSM state encoding (IDLE/WAIT/WAIT_DISCARD), and function insn_is_long.
- Sub-module moxie_insn_length is a combinational wrapper around insn_is_long. Decode reuses it.

## Test plan
- Reset release, memory returns 0x2600_2700 at 0x1000 with 1-cycle ack -> insn 0x2600 at pc 0x1000, then 0x2700 at pc 0x1002, insn_long=0 for both.
- Words 0x0100_1234, 0x5678_2600 -> insn 0x0100_1234_5678 long at 0x1000, then 0x2600 at 0x1006.
- insn_ready held 0 -> imem_req stops once count>2; outputs stable; resumes after ready=1.
- flush_pc=0x2002 while WAIT -> in-flight ack discarded; next request at 0x2000; first insn is data[15:0] at pc 0x2002.
- Flush and consume and ack in the same cycle -> buffer empties, FSM goes to WAIT_DISCARD, no instruction issued from stale data.
- Reset asserted during WAIT with a late ack -> no write; outputs at reset values; next request at 0x1000.
